exe_alu_stage: RTL

EXE_ALU_STAGE -- requirements
Module: exe_alu_stage

---
 rtl/exe_alu_stage_pkg.sv | 30 +++
 rtl/exe_alu_stage_alu.sv | 86 ++++++++
 rtl/exe_alu_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/exe_alu_stage_pkg.sv
// -----------------------------------------------------------------------------
// exe_alu_stage_pkg
// Shared processor definitions for the execute stage: ALU opcode encodings and
// the bit positions of the N, Z, C and V flags inside the 4-bit status word.
// No ports (package).
// -----------------------------------------------------------------------------
package exe_alu_stage_pkg;

    // ALU opcodes as issued by the decode stage. CMP/TST/LDR/STR reuse
    // SUB/AND/ADD with their write enables already suppressed upstream.
    typedef enum logic [3:0] {
        OP_NOP = 4'b0000,
        OP_MOV = 4'b0001,
        OP_ADD = 4'b0010,
        OP_ADC = 4'b0011,
        OP_SUB = 4'b0100,
        OP_SBC = 4'b0101,
        OP_AND = 4'b0110,
        OP_ORR = 4'b0111,
        OP_EOR = 4'b1000,
        OP_MVN = 4'b1001
    } alu_op_e;

    // Status word layout: {N, Z, C, V}
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/exe_alu_stage_alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational ALU for the execute stage. Produces the result and the
// candidate next NZCV word; the caller decides whether the flags are committed.
// Ports:
//   exe_cmd     in   4      ALU opcode
//   val_1       in   DATA_W operand 1
//   val_2       in   DATA_W shifter-operand output
//   status_cur  in   4      current registered {N,Z,C,V} (carry-in, C/V hold)
//   result      out  DATA_W ALU result
//   status_next out  4      next {N,Z,C,V}
// -----------------------------------------------------------------------------
module alu
    import exe_alu_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        exe_cmd,
    input  logic [DATA_W-1:0] val_1,
    input  logic [DATA_W-1:0] val_2,
    input  logic [3:0]        status_cur,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        status_next
);

    logic [DATA_W:0] wide_s;
    logic            is_add_s;
    logic            is_sub_s;
    logic            c_in_s;

    assign c_in_s = status_cur[FLAG_C];

    // Opcode decode and the DATA_W+1 bit arithmetic; bit DATA_W is carry/borrow.
    always_comb begin
        wide_s   = {(DATA_W+1){1'b0}};
        is_add_s = 1'b0;
        is_sub_s = 1'b0;
        case (exe_cmd)
            OP_MOV: wide_s = {1'b0, val_2};
            OP_MVN: wide_s = {1'b0, ~val_2};
            OP_ADD: begin
                wide_s   = {1'b0, val_1} + {1'b0, val_2};
                is_add_s = 1'b1;
            end
            OP_ADC: begin
                wide_s   = {1'b0, val_1} + {1'b0, val_2} + {{DATA_W{1'b0}}, c_in_s};
                is_add_s = 1'b1;
            end
            OP_SUB: begin
                wide_s   = {1'b0, val_1} - {1'b0, val_2};
                is_sub_s = 1'b1;
            end
            OP_SBC: begin
                wide_s   = {1'b0, val_1} - {1'b0, val_2} - {{DATA_W{1'b0}}, ~c_in_s};
                is_sub_s = 1'b1;
            end
            OP_AND: wide_s = {1'b0, val_1 & val_2};
            OP_ORR: wide_s = {1'b0, val_1 | val_2};
            OP_EOR: wide_s = {1'b0, val_1 ^ val_2};
            default: wide_s = {(DATA_W+1){1'b0}};
        endcase
    end

    assign result = wide_s[DATA_W-1:0];

    // Flag generation: N/Z always follow the result, C/V only for arithmetic.
    always_comb begin
        status_next         = status_cur;
        status_next[FLAG_N] = result[DATA_W-1];
        status_next[FLAG_Z] = (result == {DATA_W{1'b0}});
        if (is_add_s) begin
            status_next[FLAG_C] = wide_s[DATA_W];
            status_next[FLAG_V] = (val_1[DATA_W-1] == val_2[DATA_W-1]) &&
                                  (result[DATA_W-1] != val_1[DATA_W-1]);
        end else if (is_sub_s) begin
            // Carry is the inverted borrow: 1 means no borrow occurred.
            status_next[FLAG_C] = ~wide_s[DATA_W];
            status_next[FLAG_V] = (val_1[DATA_W-1] != val_2[DATA_W-1]) &&
                                  (result[DATA_W-1] != val_1[DATA_W-1]);
        end else begin
            status_next[FLAG_C] = status_cur[FLAG_C];
            status_next[FLAG_V] = status_cur[FLAG_V];
        end
    end

endmodule

// File: rtl/exe_alu_stage.sv
// -----------------------------------------------------------------------------
// exe_alu_stage
// Execute pipeline stage: one-cycle ALU with the EXE/MEM pipeline register and
// the NZCV status register. Priority at each edge: rst > flush > freeze > load.
// Ports:
//   clk, rst (async, active-low)
//   freeze        in  hold all state (downstream stall)
//   flush         in  kill captured instruction (valid/enables cleared)
//   in_valid      in  issue-stage instruction valid
//   exe_cmd       in  ALU opcode
//   s_update      in  instruction writes NZCV
//   val_1, val_2  in  operands
//   wb_en_in, mem_r_en_in, mem_w_en_in, dest_in, st_val_in  in  pass-through
//   out_valid, alu_res, wb_en, mem_r_en, mem_w_en, dest, st_val  out  registered
//   status        out registered {N,Z,C,V}
// -----------------------------------------------------------------------------
module exe_alu_stage
    import exe_alu_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [3:0]        exe_cmd,
    input  logic              s_update,
    input  logic [DATA_W-1:0] val_1,
    input  logic [DATA_W-1:0] val_2,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [3:0]        dest_in,
    input  logic [DATA_W-1:0] st_val_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] alu_res,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic [3:0]        dest,
    output logic [DATA_W-1:0] st_val,
    output logic [3:0]        status
);

    logic              out_valid_r;
    logic [DATA_W-1:0] alu_res_r;
    logic              wb_en_r;
    logic              mem_r_en_r;
    logic              mem_w_en_r;
    logic [3:0]        dest_r;
    logic [DATA_W-1:0] st_val_r;
    logic [3:0]        status_r;

    logic [DATA_W-1:0] result_s;
    logic [3:0]        status_next_s;

    // The ALU sees the registered flags, so an ADC right behind an S-setting
    // instruction picks up the carry written at the very same edge.
    alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .exe_cmd     (exe_cmd),
        .val_1       (val_1),
        .val_2       (val_2),
        .status_cur  (status_r),
        .result      (result_s),
        .status_next (status_next_s)
    );

    // Pipeline and status registers; flush leaves data and status untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            alu_res_r   <= {DATA_W{1'b0}};
            wb_en_r     <= 1'b0;
            mem_r_en_r  <= 1'b0;
            mem_w_en_r  <= 1'b0;
            dest_r      <= 4'b0000;
            st_val_r    <= {DATA_W{1'b0}};
            status_r    <= 4'b0000;
        end else if (flush) begin
            out_valid_r <= 1'b0;
            wb_en_r     <= 1'b0;
            mem_r_en_r  <= 1'b0;
            mem_w_en_r  <= 1'b0;
        end else if (!freeze) begin
            out_valid_r <= in_valid;
            alu_res_r   <= result_s;
            wb_en_r     <= wb_en_in & in_valid;
            mem_r_en_r  <= mem_r_en_in & in_valid;
            mem_w_en_r  <= mem_w_en_in & in_valid;
            dest_r      <= dest_in;
            st_val_r    <= st_val_in;
            if (in_valid && s_update) begin
                status_r <= status_next_s;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign alu_res   = alu_res_r;
    assign wb_en     = wb_en_r;
    assign mem_r_en  = mem_r_en_r;
    assign mem_w_en  = mem_w_en_r;
    assign dest      = dest_r;
    assign st_val    = st_val_r;
    assign status    = status_r;

endmodule
